// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the controller state encoding, the funct3 access-width codes used by
// loads and stores, the default abort limit, and small helpers that classify
// an access by width and byte offset.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    // The low two funct3 bits give the access width; every code that is not
    // byte or half (including 011/110/111) behaves as a full word.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            F3_SB[1:0]: return 1'b0;
            F3_SH[1:0]: return off[0];
            default:    return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            F3_SB[1:0]: return 4'b0001 << off;
            F3_SH[1:0]: return 4'b0011 << {off[1], 1'b0};
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_align.sv
// Combinational load alignment.
// Selects the addressed byte or halfword out of the returned memory word and
// sign- or zero-extends it according to the load funct3 code.
// Ports:
//   i_rdata   - raw 32-bit word from memory
//   i_offset  - byte offset of the access within the word
//   i_funct3  - load width/sign code
//   o_data    - aligned, extended load result
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_rdata[{i_offset, 3'b000} +: 8];
        half_sel = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_LB:   o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   o_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  o_data = {24'd0, byte_sel};
            F3_LHU:  o_data = {16'd0, half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller between the pipeline and a ready/valid memory.
// A load or store request is latched in IDLE, issued as a word-addressed
// memory request with byte strobes, and completed with a one-cycle o_done
// pulse carrying the aligned load result or a misalignment/timeout fault.
// Ports:
//   i_clk, i_rst_n                 - clock, synchronous active-low reset
//   i_mem_read, i_mem_write        - pipeline request levels
//   i_dmem_mask, i_addr, i_store_data - access width, byte address, store data
//   o_stall, o_done                - pipeline freeze and completion pulse
//   o_load_data, o_misaligned, o_timeout - completion results
//   o_dmem_req/we/addr/wdata/strb  - memory request channel
//   i_dmem_ready, i_dmem_rvalid, i_dmem_rdata - memory responses
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_dmem_mask,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_timeout,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_strb,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        sdata_q, sdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        load_data_q, load_data_d;
    logic               misaligned_q, misaligned_d;
    logic               timeout_q, timeout_d;

    logic               request;
    logic               cnt_expired;
    logic               load_beat;
    logic               in_req;
    logic [31:0]        aligned_rdata;

    assign request     = i_mem_read | i_mem_write;
    assign cnt_expired = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign in_req      = state_q == ST_REQ;
    // Load data counts as arriving either alongside the accept in REQ or later in WAIT.
    assign load_beat   = !we_q && i_dmem_rvalid &&
                         ((in_req && i_dmem_ready) || state_q == ST_WAIT);

    load_align u_load_align (
        .i_rdata  (i_dmem_rdata),
        .i_offset (addr_q[1:0]),
        .i_funct3 (funct3_q),
        .o_data   (aligned_rdata)
    );

    // Next-state logic. Completion beats the abort limit in the final allowed
    // cycle, and an accepted load that would need WAIT past the limit aborts.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        timeout_d    = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    addr_d   = i_addr;
                    sdata_d  = i_store_data;
                    funct3_d = i_dmem_mask;
                    we_d     = i_mem_write;
                    cnt_d    = '0;
                    if (is_misaligned(i_dmem_mask, i_addr[1:0])) begin
                        state_d      = ST_DONE;
                        misaligned_d = 1'b1;
                        timeout_d    = 1'b0;
                        load_data_d  = '0;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (in_req && i_dmem_ready && we_q) begin
                    state_d      = ST_DONE;
                    misaligned_d = 1'b0;
                    timeout_d    = 1'b0;
                    load_data_d  = '0;
                end else if (load_beat) begin
                    state_d      = ST_DONE;
                    misaligned_d = 1'b0;
                    timeout_d    = 1'b0;
                    load_data_d  = aligned_rdata;
                end else if (cnt_expired) begin
                    state_d      = ST_DONE;
                    misaligned_d = 1'b0;
                    timeout_d    = 1'b1;
                    load_data_d  = '0;
                end else if (in_req && i_dmem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            sdata_q      <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    // The memory channel is driven only while a request is outstanding.
    assign o_stall      = (state_q == ST_IDLE && request) || in_req || state_q == ST_WAIT;
    assign o_done       = state_q == ST_DONE;
    assign o_load_data  = load_data_q;
    assign o_misaligned = misaligned_q;
    assign o_timeout    = timeout_q;
    assign o_dmem_req   = in_req;
    assign o_dmem_we    = in_req && we_q;
    assign o_dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign o_dmem_wdata = (in_req && we_q) ? (sdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
    assign o_dmem_strb  = (in_req && we_q) ? store_strobe(funct3_q, addr_q[1:0]) : 4'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed scenarios followed by randomized accesses
// against a width/offset arithmetic model of loads, stores and faults.
module tb_dmem_ctrl;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [2:0]  i_dmem_mask = 3'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_store_data = 32'd0;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic        o_timeout;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_strb;
    logic        i_dmem_ready = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_dmem_mask  (i_dmem_mask),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_load_data  (o_load_data),
        .o_misaligned (o_misaligned),
        .o_timeout    (o_timeout),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_strb  (o_dmem_strb),
        .i_dmem_ready (i_dmem_ready),
        .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata (i_dmem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int width_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int w;
        int off;
        logic [31:0] v;
        w   = width_of(f3);
        off = int'(addr % 4);
        if (w == 4) return rdata;
        v = (rdata >> (8 * off)) & ((32'd1 << (8 * w)) - 32'd1);
        if (f3[2] == 1'b0 && v >= (32'd1 << (8 * w - 1)))
            v = v - (32'd1 << (8 * w));
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        int w;
        w = width_of(f3);
        return 4'(((1 << w) - 1) << (addr % 4));
    endfunction

    // One complete access: the memory accepts ready_delay cycles into the
    // request and (for loads) returns data rvalid_delay cycles after that.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] rdata,
                                 input int ready_delay, input int rvalid_delay,
                                 output logic [31:0] got_load, output logic [31:0] got_wdata,
                                 output logic [3:0] got_strb);
        int   w, ready_at, rvalid_at, finish_at, exp_done, cyc, done_cyc;
        logic mis, exp_to, stall_ok, saw_req, req_at_done, got_we, got_mis, got_to;
        logic [31:0] got_addr;
        w         = width_of(f3);
        mis       = (addr % w) != 0;
        ready_at  = 1 + ready_delay;
        rvalid_at = ready_at + rvalid_delay;
        finish_at = wr ? ready_at : rvalid_at;
        exp_to    = 1'b0;
        if (mis) exp_done = 1;
        else if (finish_at <= TIMEOUT) exp_done = finish_at + 1;
        else begin exp_done = TIMEOUT + 1; exp_to = 1'b1; end

        got_load = 32'd0; got_wdata = 32'd0; got_strb = 4'd0; got_addr = 32'd0;
        got_we = 1'b0; got_mis = 1'b0; got_to = 1'b0;
        stall_ok = 1'b1; saw_req = 1'b0; req_at_done = 1'b0;
        done_cyc = -1; cyc = 0;

        @(negedge i_clk);
        i_mem_read = rd; i_mem_write = wr; i_dmem_mask = f3;
        i_addr = addr; i_store_data = data;
        while (done_cyc < 0 && cyc < TIMEOUT + 10) begin
            #1;
            if (cyc == 1) begin
                i_addr = $urandom; i_dmem_mask = 3'($urandom); i_store_data = $urandom;
            end
            if (o_done) begin
                done_cyc = cyc; got_load = o_load_data; got_mis = o_misaligned;
                got_to = o_timeout; req_at_done = o_dmem_req;
                i_mem_read = 1'b0; i_mem_write = 1'b0;
            end else if (!o_stall) begin
                stall_ok = 1'b0;
            end
            if (o_dmem_req && !saw_req) begin
                saw_req = 1'b1; got_addr = o_dmem_addr; got_we = o_dmem_we;
                got_wdata = o_dmem_wdata; got_strb = o_dmem_strb;
            end
            i_dmem_ready  = (cyc == ready_at);
            i_dmem_rvalid = (!wr && cyc == rvalid_at) || cyc == 0 || o_done;
            i_dmem_rdata  = (cyc == rvalid_at) ? rdata : ~rdata;
            @(negedge i_clk);
            cyc++;
        end
        #1;
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;

        checkOutput({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
        checkOutput({tag, ".misaligned"}, {31'd0, got_mis}, {31'd0, mis});
        checkOutput({tag, ".timeout"}, {31'd0, got_to}, {31'd0, exp_to});
        checkOutput({tag, ".stall_held"}, {31'd0, stall_ok}, 32'd1);
        checkOutput({tag, ".req_off_in_done"}, {31'd0, req_at_done}, 32'd0);
        checkOutput({tag, ".req_issued"}, {31'd0, saw_req}, {31'd0, !mis});
        if (!mis) begin
            checkOutput({tag, ".addr"}, got_addr, addr & 32'hFFFF_FFFC);
            checkOutput({tag, ".we"}, {31'd0, got_we}, {31'd0, wr});
            checkOutput({tag, ".strb"}, {28'd0, got_strb}, wr ? {28'd0, model_strb(f3, addr)} : 32'd0);
            if (wr) checkOutput({tag, ".wdata"}, got_wdata, data << (8 * (addr % 4)));
        end
        if (!wr && !mis)
            checkOutput({tag, ".load_data"}, got_load, exp_to ? 32'd0 : model_load(f3, addr, rdata));
        checkOutput({tag, ".idle_no_done"}, {31'd0, o_done}, 32'd0);
        checkOutput({tag, ".idle_no_stall"}, {31'd0, o_stall}, 32'd0);
        checkOutput({tag, ".load_data_hold"}, o_load_data, got_load);
        checkOutput({tag, ".flags_hold"}, {30'd0, o_misaligned, o_timeout}, {30'd0, got_mis, got_to});
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, ".ctl"}, {25'd0, o_stall, o_done, o_misaligned, o_timeout, o_dmem_req, o_dmem_we, 1'b0}, 32'd0);
        checkOutput({tag, ".load_data"}, o_load_data, 32'd0);
        checkOutput({tag, ".dmem_addr"}, o_dmem_addr, 32'd0);
        checkOutput({tag, ".dmem_wdata"}, o_dmem_wdata, 32'd0);
        checkOutput({tag, ".dmem_strb"}, {28'd0, o_dmem_strb}, 32'd0);
    endtask

    initial begin
        logic [31:0] ld, wd;
        logic [3:0]  sb;
        logic [2:0]  f3_codes [8];
        logic [2:0]  f3;
        logic        rd, wr;
        logic [31:0] addr;
        int          rdly, vdly;
        f3_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

        repeat (3) @(negedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;

        applyStimulus("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, ld, wd, sb);
        checkOutput("sw.wdata_const", wd, 32'hDEADBEEF);
        checkOutput("sw.strb_const", {28'd0, sb}, 32'h0000000F);

        applyStimulus("sb", 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, ld, wd, sb);
        checkOutput("sb.wdata_const", wd, 32'hA5000000);
        checkOutput("sb.strb_const", {28'd0, sb}, 32'h00000008);

        applyStimulus("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1, 0, ld, wd, sb);
        checkOutput("sh.strb_const", {28'd0, sb}, 32'h0000000C);

        applyStimulus("lb", 1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080_0000, 0, 3, ld, wd, sb);
        checkOutput("lb.load_const", ld, 32'hFFFFFF80);
        applyStimulus("lbu", 1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080_0000, 0, 3, ld, wd, sb);
        checkOutput("lbu.load_const", ld, 32'h00000080);

        applyStimulus("lw_fast", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 0, ld, wd, sb);
        checkOutput("lw_fast.load_const", ld, 32'h12345678);

        applyStimulus("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, ld, wd, sb);
        applyStimulus("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, NEVER, 0, ld, wd, sb);
        checkOutput("lw_timeout.load_const", ld, 32'h0);
        applyStimulus("sw_last_cycle", 1'b0, 1'b1, 3'b010, 32'h500, 32'h55AA55AA, 32'h0, TIMEOUT - 1, 0, ld, wd, sb);
        applyStimulus("sw_one_late", 1'b0, 1'b1, 3'b010, 32'h500, 32'h55AA55AA, 32'h0, TIMEOUT, 0, ld, wd, sb);
        applyStimulus("lw_wait_timeout", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h1, 2, 20, ld, wd, sb);
        applyStimulus("rw_both", 1'b1, 1'b1, 3'b010, 32'h700, 32'h0BADF00D, 32'h0, 0, 0, ld, wd, sb);

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3   = f3_codes[$urandom_range(0, 7)];
            if (wr && (f3 == 3'b100 || f3 == 3'b101)) f3 = 3'b010;
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            rdly = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
            vdly = int'($urandom_range(0, 3));
            applyStimulus($sformatf("rand%0d", n), rd, wr, f3, addr, $urandom, $urandom,
                          rdly, vdly, ld, wd, sb);
        end

        // Reset while a load waits for data; the late data must be ignored.
        @(negedge i_clk);
        i_mem_read = 1'b1; i_dmem_mask = 3'b010; i_addr = 32'h800;
        @(negedge i_clk);
        i_dmem_ready = 1'b1;
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        #1;
        checkOutput("rst_mid.in_wait_stall", {31'd0, o_stall}, 32'd1);
        i_rst_n = 1'b0; i_mem_read = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_all_zero("rst_mid");
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hFFFF_FFFF;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_all_zero($sformatf("rst_late%0d", k));
            @(negedge i_clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
